// File: rtl/update_sequencer.sv
// update_sequencer: queues host edge updates and issues them to the graph
// container one run at a time (pulse container_reset, hold u_*, wait done).
module update_sequencer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned PRED_WIDTH   = 7,
  parameter int unsigned WEIGHT_WIDTH = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    chipselect,
  input  logic                    write,
  input  logic                    read,
  input  logic [1:0]              address,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [PRED_WIDTH:0]     src,
  output logic [PRED_WIDTH:0]     u_src,
  output logic [PRED_WIDTH:0]     u_dst,
  output logic [WEIGHT_WIDTH:0]   u_e,
  output logic                    container_reset,
  input  logic                    container_done
);

  localparam int unsigned V_W   = PRED_WIDTH + 1;
  localparam int unsigned W_W   = WEIGHT_WIDTH + 1;
  localparam int unsigned E_W   = 2 * V_W + W_W;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    GUARD     = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;

  logic [V_W-1:0]     src_stage_q, src_stage_d;
  logic [V_W-1:0]     dst_stage_q, dst_stage_d;
  logic [V_W-1:0]     src_q, src_d;
  logic [V_W-1:0]     u_src_q, u_src_d;
  logic [V_W-1:0]     u_dst_q, u_dst_d;
  logic [W_W-1:0]     u_e_q, u_e_d;
  logic               creset_q, creset_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   completed_q, completed_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   count_q, count_d;
  logic [E_W-1:0]     mem_q [DEPTH];

  logic               wr_en_c, rd_en_c, push_req_c, push_ok_c;
  logic               empty_c, full_c, busy_c;
  logic               pop_c, run_done_c;
  logic [E_W-1:0]     head_c;
  logic               unused_wdata_c;

  assign wr_en_c    = chipselect & write;
  assign rd_en_c    = chipselect & read;
  assign push_req_c = wr_en_c && (address == 2'd2);
  assign empty_c    = (count_q == '0);
  assign full_c     = (count_q == LVL_W'(DEPTH));
  assign head_c     = mem_q[rd_ptr_q];
  assign unused_wdata_c = ^writedata[31:W_W];

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic; done is only honoured in WAIT_DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty_c) state_d = LAUNCH;
      LAUNCH:    state_d = GUARD;
      GUARD:     state_d = WAIT_DONE;
      WAIT_DONE: if (container_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs: pop/launch in IDLE, completion in WAIT_DONE
  always_comb begin
    pop_c      = 1'b0;
    run_done_c = 1'b0;
    busy_c     = (state_q != IDLE);
    creset_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        pop_c    = !empty_c;
        creset_d = !empty_c;
      end
      WAIT_DONE: run_done_c = container_done;
      default: ;
    endcase
  end

  // FIFO bookkeeping, host registers and issued fields
  always_comb begin
    push_ok_c   = push_req_c && (!full_c || pop_c);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    src_stage_d = src_stage_q;
    dst_stage_d = dst_stage_q;
    src_d       = src_q;
    u_src_d     = u_src_q;
    u_dst_d     = u_dst_q;
    u_e_d       = u_e_q;
    completed_d = completed_q;

    if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      {u_src_d, u_dst_d, u_e_d} = head_c;
    end
    unique case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_en_c) begin
      unique case (address)
        2'd0: src_stage_d = writedata[PRED_WIDTH:0];
        2'd1: dst_stage_d = writedata[PRED_WIDTH:0];
        2'd2: if (!push_ok_c) overflow_d = 1'b1;
        2'd3: begin
          src_d      = writedata[PRED_WIDTH:0];
          overflow_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (run_done_c) completed_d = completed_q + CNT_W'(1);
  end

  // Read mux; readdata holds between reads
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en_c) begin
      unique case (address)
        2'd0: readdata_d = {overflow_q, busy_c, full_c, empty_c, 19'd0, 9'(count_q)};
        2'd1: readdata_d = 32'({u_src_q, u_dst_q});
        2'd2: readdata_d = 32'(completed_q);
        2'd3: readdata_d = 32'(src_q);
        default: readdata_d = readdata_q;
      endcase
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_stage_q <= '0;
      dst_stage_q <= '0;
      src_q       <= '0;
      u_src_q     <= '0;
      u_dst_q     <= '0;
      u_e_q       <= '0;
      creset_q    <= 1'b0;
      readdata_q  <= '0;
      overflow_q  <= 1'b0;
      completed_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      src_stage_q <= src_stage_d;
      dst_stage_q <= dst_stage_d;
      src_q       <= src_d;
      u_src_q     <= u_src_d;
      u_dst_q     <= u_dst_d;
      u_e_q       <= u_e_d;
      creset_q    <= creset_d;
      readdata_q  <= readdata_d;
      overflow_q  <= overflow_d;
      completed_q <= completed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= {src_stage_q, dst_stage_q, writedata[WEIGHT_WIDTH:0]};
  end

  assign readdata        = readdata_q;
  assign src             = src_q;
  assign u_src           = u_src_q;
  assign u_dst           = u_dst_q;
  assign u_e             = u_e_q;
  assign container_reset = creset_q;

endmodule

// File: tb/tb_update_sequencer.sv
// Directed bench for update_sequencer with a small container-side monitor.
module tb_update_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [7:0]  src, u_src, u_dst;
  logic [15:0] u_e;
  logic        container_reset;
  logic        container_done = 1'b0;

  always #5 clk = ~clk;

  update_sequencer #(
    .DEPTH(16), .CNT_W(16), .PRED_WIDTH(7), .WEIGHT_WIDTH(15)
  ) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata), .readdata(readdata),
    .src(src), .u_src(u_src), .u_dst(u_dst), .u_e(u_e),
    .container_reset(container_reset), .container_done(container_done)
  );

  int vectors = 0;
  int miscompares = 0;

  // container-side monitor: logs each pulse and flags overlaps / unexpected u_* changes
  int          pulse_cnt = 0;
  int          overlap_err = 0;
  int          u_change_err = 0;
  logic        prev_creset = 1'b0;
  logic [31:0] prev_u = 32'd0;
  logic [7:0]  log_src[$];
  logic [7:0]  log_dst[$];
  logic [15:0] log_e[$];

  always @(posedge clk) begin
    if (!reset_n) begin
      prev_creset = 1'b0;
      prev_u = {u_src, u_dst, u_e};
    end else begin
      if (container_reset) begin
        pulse_cnt++;
        log_src.push_back(u_src);
        log_dst.push_back(u_dst);
        log_e.push_back(u_e);
        if (prev_creset) overlap_err++;
      end
      if ({u_src, u_dst, u_e} !== prev_u && !container_reset) u_change_err++;
      prev_creset = container_reset;
      prev_u = {u_src, u_dst, u_e};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_pulses(input int target);
    int n = 0;
    while (pulse_cnt < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (pulse_cnt < target) begin
      $display("FAIL pulse_timeout: pulses=%0d required=%0d", pulse_cnt, target);
      miscompares++;
    end
  endtask

  task automatic finish_run();
    @(negedge clk); container_done = 1'b1;
    @(negedge clk); container_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({readdata, src, u_src, u_dst, u_e, container_reset} !== 65'd0) begin
      $display("FAIL reset_outputs: got rd=%h src=%h us=%h ud=%h ue=%h cr=%b required all zero",
               readdata, src, u_src, u_dst, u_e, container_reset);
      miscompares++;
    end
    @(negedge clk); reset_n = 1'b1;
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'h1000_0000) begin
      $display("FAIL reset_status: got %h required %h", rd, 32'h1000_0000);
      miscompares++;
    end
  endtask

  task automatic test_single();
    logic [31:0] rd;
    int pc0;
    pc0 = pulse_cnt;
    bus_write(2'd0, 32'd3);
    bus_write(2'd1, 32'd5);
    bus_write(2'd2, 32'h2A);
    @(posedge clk); #1;
    vectors++;
    if ({container_reset, u_src, u_dst, u_e} !== {1'b1, 8'd3, 8'd5, 16'h2A}) begin
      $display("FAIL single_issue: got cr=%b %h/%h/%h required 1 03/05/002a",
               container_reset, u_src, u_dst, u_e);
      miscompares++;
    end
    @(posedge clk); #1;
    vectors++;
    if (container_reset !== 1'b0) begin
      $display("FAIL single_pulse_width: got %b required 0", container_reset);
      miscompares++;
    end
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if ({pulse_cnt - pc0, u_src, u_dst, u_e} !== {32'd1, 8'd3, 8'd5, 16'h2A}) begin
      $display("FAIL single_hold: got pulses=%0d %h/%h/%h required 1 03/05/002a",
               pulse_cnt - pc0, u_src, u_dst, u_e);
      miscompares++;
    end
    finish_run();
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd1) begin
      $display("FAIL single_completed: got %0d required 1", rd);
      miscompares++;
    end
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'h1000_0000) begin
      $display("FAIL single_status: got %h required %h", rd, 32'h1000_0000);
      miscompares++;
    end
    bus_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0305) begin
      $display("FAIL single_readback: got %h required %h", rd, 32'h0000_0305);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int pc0, lb;
    pc0 = pulse_cnt;
    lb = log_e.size();
    bus_write(2'd0, 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus_write(2'd1, 32'(k + 2));
      bus_write(2'd2, 32'(k + 10));
    end
    for (int i = 0; i < 4; i++) begin
      wait_pulses(pc0 + i + 1);
      repeat (10) @(posedge clk);
      @(negedge clk); container_done = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); container_done = 1'b0;
      @(posedge clk); #1;
      if (i < 3) begin
        vectors++;
        if (container_reset !== 1'b1) begin
          $display("FAIL b2b_next_pop run%0d: got cr=%b required 1", i, container_reset);
          miscompares++;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({log_src[lb+i], log_dst[lb+i], log_e[lb+i]} !== {8'd1, 8'(i + 2), 16'(i + 10)}) begin
        $display("FAIL b2b_order run%0d: got %h/%h/%h required 01/%h/%h",
                 i, log_src[lb+i], log_dst[lb+i], log_e[lb+i], 8'(i + 2), 16'(i + 10));
        miscompares++;
      end
    end
    vectors++;
    if (overlap_err !== 0 || u_change_err !== 0) begin
      $display("FAIL b2b_integrity: got overlap=%0d uchange=%0d required 0/0", overlap_err, u_change_err);
      miscompares++;
    end
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd5) begin
      $display("FAIL b2b_completed: got %0d required 5", rd);
      miscompares++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    bus_write(2'd0, 32'd7);
    bus_write(2'd1, 32'd8);
    for (int k = 0; k < 17; k++) bus_write(2'd2, 32'(32'h100 + k));
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'h6000_0010) begin
      $display("FAIL ovf_full_status: got %h required %h", rd, 32'h6000_0010);
      miscompares++;
    end
    bus_write(2'd2, 32'hEE);
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'hE000_0010) begin
      $display("FAIL ovf_set_status: got %h required %h", rd, 32'hE000_0010);
      miscompares++;
    end
    bus_write(2'd3, 32'd9);
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'h6000_0010) begin
      $display("FAIL ovf_clear_status: got %h required %h", rd, 32'h6000_0010);
      miscompares++;
    end
    bus_read(2'd3, rd);
    vectors++;
    if (rd !== 32'd9) begin
      $display("FAIL ovf_src_readback: got %h required 9", rd);
      miscompares++;
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rd;
    int pc0, lb;
    pc0 = pulse_cnt;
    lb = log_e.size();
    @(negedge clk); container_done = 1'b1;
    @(negedge clk); container_done = 1'b0;
    chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'hBB;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    vectors++;
    if ({container_reset, u_e} !== {1'b1, 16'h101}) begin
      $display("FAIL fpp_pop: got cr=%b ue=%h required 1 0101", container_reset, u_e);
      miscompares++;
    end
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'h6000_0010) begin
      $display("FAIL fpp_status: got %h required %h", rd, 32'h6000_0010);
      miscompares++;
    end
    for (int i = 0; i < 17; i++) begin
      wait_pulses(pc0 + i + 1);
      repeat (2) @(posedge clk);
      finish_run();
    end
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (log_e.size() !== lb + 17) begin
      $display("FAIL fpp_run_count: got %0d required %0d", log_e.size() - lb, 17);
      miscompares++;
    end
    for (int i = 0; i < 17; i++) begin
      vectors++;
      if ({log_src[lb+i], log_dst[lb+i], log_e[lb+i]} !==
          {8'd7, 8'd8, (i < 16) ? 16'(16'h101 + i) : 16'hBB}) begin
        $display("FAIL fpp_order run%0d: got %h/%h/%h required 07/08/%h", i,
                 log_src[lb+i], log_dst[lb+i], log_e[lb+i], (i < 16) ? 16'(16'h101 + i) : 16'hBB);
        miscompares++;
      end
    end
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd23) begin
      $display("FAIL fpp_completed: got %0d required 23", rd);
      miscompares++;
    end
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'h1000_0000) begin
      $display("FAIL fpp_idle_status: got %h required %h", rd, 32'h1000_0000);
      miscompares++;
    end
  endtask

  task automatic test_stale_done();
    logic [31:0] rd;
    int pc0;
    pc0 = pulse_cnt;
    @(negedge clk); container_done = 1'b1;
    repeat (3) @(posedge clk);
    bus_write(2'd2, 32'h33);
    @(posedge clk); #1;
    vectors++;
    if ({container_reset, u_e} !== {1'b1, 16'h33}) begin
      $display("FAIL stale_issue: got cr=%b ue=%h required 1 0033", container_reset, u_e);
      miscompares++;
    end
    @(posedge clk);
    @(posedge clk); #1;
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'h5000_0000) begin
      $display("FAIL stale_guard_busy: got %h required %h", rd, 32'h5000_0000);
      miscompares++;
    end
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd24) begin
      $display("FAIL stale_completed: got %0d required 24", rd);
      miscompares++;
    end
    repeat (5) @(posedge clk);
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd24 || pulse_cnt !== pc0 + 1) begin
      $display("FAIL stale_once: got completed=%0d pulses=%0d required 24/1", rd, pulse_cnt - pc0);
      miscompares++;
    end
    @(negedge clk); container_done = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] rd;
    int pc0;
    for (int k = 0; k < 4; k++) bus_write(2'd2, 32'(32'h41 + k));
    repeat (5) @(posedge clk);
    bus_read(2'd1, rd);
    vectors++;
    if (rd !== 32'h0000_0708) begin
      $display("FAIL midrun_pre_readback: got %h required %h", rd, 32'h0000_0708);
      miscompares++;
    end
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({readdata, src, u_src, u_dst, u_e, container_reset} !== 65'd0) begin
      $display("FAIL midrun_async_reset: got rd=%h src=%h us=%h ud=%h ue=%h cr=%b required all zero",
               readdata, src, u_src, u_dst, u_e, container_reset);
      miscompares++;
    end
    pc0 = pulse_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    bus_read(2'd0, rd);
    vectors++;
    if (rd !== 32'h1000_0000) begin
      $display("FAIL midrun_status: got %h required %h", rd, 32'h1000_0000);
      miscompares++;
    end
    bus_read(2'd3, rd);
    vectors++;
    if (rd !== 32'd0) begin
      $display("FAIL midrun_src: got %h required 0", rd);
      miscompares++;
    end
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (pulse_cnt !== pc0) begin
      $display("FAIL midrun_no_launch: got %0d pulses required 0", pulse_cnt - pc0);
      miscompares++;
    end
    bus_write(2'd0, 32'd2);
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'h55);
    wait_pulses(pc0 + 1);
    vectors++;
    if ({log_src[$], log_dst[$], log_e[$]} !== {8'd2, 8'd4, 16'h55}) begin
      $display("FAIL midrun_new_run: got %h/%h/%h required 02/04/0055",
               log_src[$], log_dst[$], log_e[$]);
      miscompares++;
    end
    repeat (2) @(posedge clk);
    finish_run();
    bus_read(2'd2, rd);
    vectors++;
    if (rd !== 32'd1) begin
      $display("FAIL midrun_completed: got %0d required 1", rd);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_stale_done();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/update_sequencer.md
# update_sequencer

Host-side initiator for the arbitrage core's update port. Host writes (edge updates from the software feed) are queued in a FIFO. Each entry is then issued to the graph container as a single run: drive `u_src`/`u_dst`/`u_e`, pulse `container_reset` for one cycle, hold the fields stable, and wait for `container_done`. Only then is the next entry issued. The block sits between the HPS bus slave and the container, and guarantees at most one container run in flight.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- CNT_W, 16: width of completed-run counter.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- chipselect  in  1  bus select; qualifies read/write.
- write  in  1  bus write strobe.
- read  in  1  bus read strobe.
- address  in  2  register index (map below).
- writedata  in  32  bus write data.
- readdata  out  32  registered read data.
- src  out  `PRED_WIDTH`+1  Bellman source vertex.
- u_src  out  `PRED_WIDTH`+1  update source vertex.
- u_dst  out  `PRED_WIDTH`+1  update destination vertex.
- u_e  out  `WEIGHT_WIDTH`+1  update edge weight.
- container_reset  out  1  one-cycle active-high run start to container.
- container_done  in  1  container run complete; level, cleared by container_reset.

## Operation
Register map, writes (chipselect&write):
- Address 0: src_stage <= writedata[`PRED_WIDTH`:0].
- Address 1: dst_stage <= writedata[`PRED_WIDTH`:0].
- Address 2: push {src_stage, dst_stage, writedata[`WEIGHT_WIDTH`:0]}. Staging registers are unchanged, so repeated weight writes reuse the same vertices.
- Address 3: src <= writedata[`PRED_WIDTH`:0]; clears overflow.

Register map, reads (chipselect&read):
- Address 0: status = {overflow[31], busy[30], full[29], empty[28], 0…, count[8:0]}.
- Address 1: {0…, u_src, u_dst} currently issued; u_dst occupies the low `PRED_WIDTH`+1 bits.
- Address 2: completed counter, zero-extended.
- Address 3: src, zero-extended.

FIFO behaviour:
- Circular buffer with wrapping read/write pointers and a count of 0..DEPTH.
- A push is accepted when count<DEPTH, or when a pop occurs in the same cycle.
- Otherwise the push is dropped, overflow is set (sticky) and the FIFO is unchanged.

FSM states IDLE, LAUNCH, GUARD, WAIT_DONE:
- IDLE: if !empty, pop the head into u_src/u_dst/u_e → LAUNCH. Else stay.
- LAUNCH: container_reset=1 → GUARD.
- GUARD: container_reset=0; container_done ignored → WAIT_DONE.
- WAIT_DONE: on container_done=1, increment completed (wraps at 2^CNT_W) → IDLE.
- busy = state≠IDLE.
- u_src/u_dst/u_e change only on a pop in IDLE and are held through the whole run.
- src changes only by host write. Software writes src only while idle; this block does not block writes during a run.
- No timeout: WAIT_DONE holds indefinitely until done or reset.

Reset (reset_n low, asynchronous):
- Outputs: readdata=0, src=0, u_src=0, u_dst=0, u_e=0, container_reset=0.
- Internal: state=IDLE, pointers/count=0, overflow=0, completed=0, staging registers=0.
- Reset mid-run abandons the run. Queued entries are lost; no container_reset is issued until a new push.

## Timing
- Write-to-push: an entry written at edge N is visible in count at N+1.
- Issue latency:
  - With IDLE and the FIFO empty, a push at edge N moves the entry to u_* at N+1 (pop in IDLE).
  - container_reset is high in the cycle N+1..N+2.
- Container run: the container samples u_* in the two cycles after container_reset. u_* are stable from pop to WAIT_DONE exit.
- Back-to-back runs: done seen at edge M → IDLE at M; the next pop at M+1. container_reset is never asserted while busy, except in LAUNCH.
- Read latency: readdata is valid the cycle after the read strobe and holds its value until the next read.
- Simultaneous push + pop when full: both occur; count stays DEPTH, no overflow.
- Simultaneous push + pop when count=1: the pop takes the old head; count stays 1.

## Test plan
- Single update: write src_stage=3, dst_stage=5, weight=0x2A at addr 2 → one container_reset pulse with u_src=3, u_dst=5, u_e=0x2A stable until done; raise done 20 cycles later → completed=1, busy=0.
- Queue of 4 with done delayed 10 cycles each → four container_reset pulses, in push order, never overlapping; u_* constant between pulses; completed=4.
- Fill to DEPTH=16 with done held low, push a 17th → overflow=1, full=1, count=16; write addr 3 → overflow=0, and the 17th entry is never issued.
- Full FIFO, pop and push in the same cycle (release done) → no overflow; the new entry is issued last.
- Stale done: container_done held high before the first push → the run still waits through GUARD, completed increments exactly once per pulse.
- Assert reset_n low in WAIT_DONE with 3 entries queued → all outputs 0 immediately (asynchronously), count=0; after release, no container_reset until a new push.
